// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the register controls returned to it.
interface pipeline_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(parameter int CNT_W = 16);
   logic [REG_W-1:0] id_src1;
   logic [REG_W-1:0] id_src2;
   logic             id_two_src;
   logic [REG_W-1:0] ex_dest;
   logic             ex_mem_r_en;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_en;
   logic             id_ex_flush;
   logic             ex_mem_en;
   logic             mem_wb_bubble;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_src1, id_src2, id_two_src, ex_dest, ex_mem_r_en,
             branch_taken, mem_req, mem_ready,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_en, mem_wb_bubble, mem_timeout, stall_count
   );
   modport slave (
      input  id_src1, id_src2, id_two_src, ex_dest, ex_mem_r_en,
             branch_taken, mem_req, mem_ready,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_en, mem_wb_bubble, mem_timeout, stall_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: ID reads a register that the load in EX has not written yet.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic [REG_W-1:0] ex_dest,
   input  logic             ex_mem_r_en,
   output logic             hazard
);
   // $zero is never a real dependency, it always reads as 0
   assign hazard = ex_mem_r_en && (ex_dest != ZERO_REG) &&
                   ((ex_dest == id_src1) || (id_two_src && (ex_dest == id_src2)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline with memory-wait watchdog
// and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

   state_t           state, state_n;
   logic [7:0]       wait_cnt, wait_cnt_n;
   logic             timeout_n;
   logic             hazard;
   logic             mstall;
   logic [CNT_W-1:0] stall_count;
   logic             mem_timeout;

   load_use_detect u_lud (
      .id_src1     (bus.id_src1),
      .id_src2     (bus.id_src2),
      .id_two_src  (bus.id_two_src),
      .ex_dest     (bus.ex_dest),
      .ex_mem_r_en (bus.ex_mem_r_en),
      .hazard      (hazard)
   );

   assign mstall = bus.mem_req & ~bus.mem_ready;

   // Output priority: reset, halt, memory stall, branch, load-use
   always_comb begin
      bus.pc_en         = 1'b1;
      bus.if_id_en      = 1'b1;
      bus.if_id_flush   = 1'b0;
      bus.id_ex_en      = 1'b1;
      bus.id_ex_flush   = 1'b0;
      bus.ex_mem_en     = 1'b1;
      bus.mem_wb_bubble = 1'b0;
      if (rst) begin
         bus.pc_en         = 1'b0;
         bus.if_id_en      = 1'b0;
         bus.id_ex_en      = 1'b0;
         bus.ex_mem_en     = 1'b0;
         bus.if_id_flush   = 1'b1;
         bus.id_ex_flush   = 1'b1;
         bus.mem_wb_bubble = 1'b1;
      end else if (state == HALT || mstall) begin
         bus.pc_en         = 1'b0;
         bus.if_id_en      = 1'b0;
         bus.id_ex_en      = 1'b0;
         bus.ex_mem_en     = 1'b0;
         bus.mem_wb_bubble = 1'b1;
      end else if (bus.branch_taken) begin
         bus.if_id_flush = 1'b1;
         bus.id_ex_flush = 1'b1;
      end else if (hazard) begin
         bus.pc_en       = 1'b0;
         bus.if_id_en    = 1'b0;
         bus.id_ex_flush = 1'b1;
      end
   end

   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      timeout_n  = mem_timeout;
      case (state)
         RUN: if (mstall) begin
            state_n    = WAIT;
            wait_cnt_n = 8'd1;
         end
         WAIT: if (!mstall) begin
            state_n    = RUN;
            wait_cnt_n = 8'd0;
         end else if (wait_cnt == MAX_WAIT_W) begin
            state_n   = HALT;
            timeout_n = 1'b1;
         end else begin
            wait_cnt_n = wait_cnt + 8'd1;
         end
         default: state_n = HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         stall_count <= '0;
      end else begin
         state       <= state_n;
         wait_cnt    <= wait_cnt_n;
         mem_timeout <= timeout_n;
         if (!bus.pc_en && stall_count != '1)
            stall_count <= stall_count + 1'b1;
      end
   end

   assign bus.mem_timeout = mem_timeout;
   assign bus.stall_count = stall_count;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MAX_WAIT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;
   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 4;

   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble}
   localparam logic [6:0] C_NORM   = 7'b1101010;
   localparam logic [6:0] C_FREEZE = 7'b0000001;
   localparam logic [6:0] C_BRANCH = 7'b1111110;
   localparam logic [6:0] C_LU     = 7'b0001110;
   localparam logic [6:0] C_RST    = 7'b0010101;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   wire [6:0] ctl = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
                     bus.id_ex_flush, bus.ex_mem_en, bus.mem_wb_bubble};

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle();
      bus.id_src1 = 5'd1; bus.id_src2 = 5'd2; bus.id_two_src = 1'b0;
      bus.ex_dest = 5'd0; bus.ex_mem_r_en = 1'b0; bus.branch_taken = 1'b0;
      bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; #1;
      check("rst_ctl", 16'(ctl), 16'(C_RST));
      tick();
      rst = 1'b0; #1;
   endtask

   initial begin
      idle();
      #1;
      check("reset_ctl", 16'(ctl), 16'(C_RST));
      check("reset_cnt", 16'(bus.stall_count), 16'd0);
      check("reset_to",  16'(bus.mem_timeout), 16'd0);
      tick();
      rst = 1'b0; #1;
      check("idle_ctl", 16'(ctl), 16'(C_NORM));

      // load-use: one bubble cycle
      bus.ex_mem_r_en = 1'b1; bus.ex_dest = 5'd8; bus.id_src1 = 5'd8; #1;
      check("lu_ctl", 16'(ctl), 16'(C_LU));
      tick();
      idle(); #1;
      check("lu_cnt", 16'(bus.stall_count), 16'd1);
      check("lu_clear", 16'(ctl), 16'(C_NORM));

      // zero register and single-source cases, combinational only
      bus.ex_mem_r_en = 1'b1; bus.ex_dest = 5'd0; bus.id_src1 = 5'd0; #1;
      check("zero_reg", 16'(ctl), 16'(C_NORM));
      bus.ex_dest = 5'd9; bus.id_src1 = 5'd3; bus.id_src2 = 5'd9; bus.id_two_src = 1'b0; #1;
      check("one_src", 16'(ctl), 16'(C_NORM));
      bus.id_two_src = 1'b1; #1;
      check("two_src", 16'(ctl), 16'(C_LU));
      idle(); #1;

      // taken branch: flush, no stall count
      bus.branch_taken = 1'b1; #1;
      check("br_ctl", 16'(ctl), 16'(C_BRANCH));
      tick();
      idle(); #1;
      check("br_cnt", 16'(bus.stall_count), 16'd1);

      // memory wait of 3 cycles
      do_reset();
      check("mw_cnt0", 16'(bus.stall_count), 16'd0);
      bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("mw_frz%0d", i), 16'(ctl), 16'(C_FREEZE));
         tick();
      end
      bus.mem_ready = 1'b1; #1;
      check("mw_rel", 16'(ctl), 16'(C_NORM));
      check("mw_cnt", 16'(bus.stall_count), 16'd3);
      tick();
      idle(); #1;
      check("mw_run", 16'(ctl), 16'(C_NORM));
      check("mw_to", 16'(bus.mem_timeout), 16'd0);

      // branch collides with a memory stall
      bus.branch_taken = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0; #1;
      check("col_frz", 16'(ctl), 16'(C_FREEZE));
      tick();
      bus.mem_ready = 1'b1; #1;
      check("col_rel", 16'(ctl), 16'(C_BRANCH));
      tick();
      idle(); #1;
      check("col_cnt", 16'(bus.stall_count), 16'd4);

      // watchdog: halt at the edge ending the 5th stall cycle
      do_reset();
      bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("to_pre", 16'(bus.mem_timeout), 16'd0);
      tick();
      check("to_set", 16'(bus.mem_timeout), 16'd1);
      bus.mem_ready = 1'b1; #1;
      check("halt_ctl", 16'(ctl), 16'(C_FREEZE));
      tick();
      check("halt_cnt", 16'(bus.stall_count), 16'd6);
      check("halt_stay", 16'(ctl), 16'(C_FREEZE));
      idle();
      rst = 1'b1; #1;
      check("async_rst_cnt", 16'(bus.stall_count), 16'd0);
      check("async_rst_to", 16'(bus.mem_timeout), 16'd0);
      check("async_rst_ctl", 16'(ctl), 16'(C_RST));
      tick();
      rst = 1'b0; #1;
      check("post_rst", 16'(ctl), 16'(C_NORM));

      // saturation: 20 load-use stalls on a 4-bit counter
      bus.ex_mem_r_en = 1'b1; bus.ex_dest = 5'd12; bus.id_src2 = 5'd12; bus.id_two_src = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      check("sat_15", 16'(bus.stall_count), 16'd15);
      for (int i = 0; i < 5; i++) tick();
      check("sat_hold", 16'(bus.stall_count), 16'd15);
      idle(); #1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
